fan_button_conditioner: RTL and testbench
=========================================

// Module: fan_button_conditioner
// PURPOSE
//   Front end of the fan control panel; drives the signal/add/minus inputs of the fan speed controller.
//   Conditions three raw push buttons (power, add, minus): 2-flop synchronizer, debounce, edge-to-pulse.
//   add/minus auto-repeat while held, so the controller steps speed one level per pulse.
//   Every output is a clean one-cycle, clk-synchronous pulse.
// PARAMETERS
//   DEBOUNCE_CYCLES  4  consecutive stable synchronized samples needed to accept a level change (>=1)
//   REPEAT_DELAY     8  cycles from first add/minus pulse to first repeat pulse (>=1)
//   REPEAT_PERIOD    4  cycles between subsequent repeat pulses (>=1)
// PORTS
//   clk            input   1  system clock, all logic on rising edge
//   rst            input   1  synchronous, active-high reset
//   power_btn_raw  input   1  raw power button, asynchronous, 1 = pressed
//   add_btn_raw    input   1  raw speed-up button, asynchronous, 1 = pressed
//   minus_btn_raw  input   1  raw speed-down button, asynchronous, 1 = pressed
//   signal         output  1  one-cycle on/off toggle pulse to fan controller
//   add            output  1  one-cycle speed-up pulse
//   minus          output  1  one-cycle speed-down pulse
// BEHAVIOUR
//   Reset: signal=add=minus=0; synchronizers, debounced levels and counters cleared; FSMs in IDLE.
//     Reset has priority over all other activity in the same cycle.
//   Sync: each raw input passes through 2 flops before any other logic.
//   Debounce, per channel:
//     - The counter increments while the synchronized value differs from the debounced level.
//     - It clears on any cycle where the two match.
//     - When the count reaches DEBOUNCE_CYCLES, the debounced level flips and the counter clears.
//   Latency: E0 = first rising edge that samples the raw input high, with the input held.
//     Pulse is registered high at edge E0+DEBOUNCE_CYCLES+2 and stays high for exactly 1 cycle.
//   Power channel:
//     - One signal pulse per debounced rising edge; no repeat.
//     - Release produces no pulse.
//   Add/minus channels, one FSM each:
//     IDLE  -> on debounced rise: pulse, load delay counter, go DELAY.
//     DELAY -> count REPEAT_DELAY cycles; if still pressed at expiry: pulse, go REPEAT.
//     REPEAT-> pulse every REPEAT_PERIOD cycles while pressed.
//     Any state -> on debounced release: IDLE, no pulse, counters cleared.
//     LOCK  -> on debounced release: IDLE (see conflict rule).
//   Pulse schedule while held: first pulse P, then P+REPEAT_DELAY, then +REPEAT_PERIOD each time after.
//   Conflict rule:
//     - Both add and minus debounced pressed in the same cycle: both FSMs enter LOCK.
//     - No add or minus pulse is issued in that cycle.
//     - A channel leaves LOCK only via its own release; a new press is needed to pulse again.
//   Power priority:
//     - A cycle with signal=1 masks add and minus to 0; the masked pulse is dropped.
//     - FSM timing is unaffected by the mask.
//   Reset mid-press: the button is treated as released.
//     If still held after rst falls, it is debounced as a new press and yields a first pulse.
//   Counter widths = $clog2(max param + 1); counters saturate, never wrap.
//   Outputs are registered; no combinational path from inputs to outputs.
// TESTING (defaults D=4, RD=8, RP=4)
//   1. power_btn_raw high 20 cycles from E0 -> signal=1 only at E0+6, one cycle; no pulse on release.
//   2. add_btn_raw glitch high 3 cycles -> add never asserts; a 4-cycle high run -> one add pulse.
//   3. add held 30 cycles -> add pulses at P, P+8, P+12, P+16, P+20, P+24, ...
//      then none once the debounced release occurs.
//   4. minus held, then add pressed while minus still held -> no add or minus pulses during overlap.
//      Both must be released; a re-pressed add then pulses normally at E0+6.
//   5. power and add rise on the same edge -> signal pulses, add masked that cycle.
//      add repeat pulse still appears at P+8.
//   6. rst asserted 2 cycles during add REPEAT, button held -> outputs 0 during rst.
//      After rst release, a fresh first pulse appears 6 edges later; repeats follow at +8, then +4.

Source files
------------

// File: rtl/fan_button_conditioner.sv
// fan_button_conditioner: synchronizes and debounces the power/add/minus buttons, then
// turns them into one-cycle pulses, with auto-repeat on add/minus.
module fan_button_conditioner #(
    parameter int DEBOUNCE_CYCLES = 4,
    parameter int REPEAT_DELAY    = 8,
    parameter int REPEAT_PERIOD   = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic power_btn_raw,
    input  logic add_btn_raw,
    input  logic minus_btn_raw,
    output logic signal,
    output logic add,
    output logic minus
);
    localparam int DW   = $clog2(DEBOUNCE_CYCLES + 1);
    localparam int RMAX = REPEAT_DELAY > REPEAT_PERIOD ? REPEAT_DELAY : REPEAT_PERIOD;
    localparam int RW   = $clog2(RMAX + 1);
    localparam logic [DW-1:0] D_LAST = DW'(DEBOUNCE_CYCLES - 1);
    localparam logic [RW-1:0] RD_L   = RW'(REPEAT_DELAY);
    localparam logic [RW-1:0] RP_L   = RW'(REPEAT_PERIOD);
    localparam logic [1:0] IDLE   = 2'd0;
    localparam logic [1:0] DELAY  = 2'd1;
    localparam logic [1:0] REPEAT = 2'd2;
    localparam logic [1:0] LOCK   = 2'd3;

    logic [2:0] raw, s1, s2, lvl, lvl_q;
    logic [DW-1:0] dcnt [3];
    logic [1:0] st [2];
    logic [1:0] st_n [2];
    logic [RW-1:0] rcnt [2];
    logic [RW-1:0] rcnt_n [2];
    logic [1:0] pls;
    logic sig_n, both;

    assign raw   = {minus_btn_raw, add_btn_raw, power_btn_raw};
    assign both  = lvl[1] & lvl[2];
    assign sig_n = lvl[0] & ~lvl_q[0];

    // Channel order: 0 = power, 1 = add, 2 = minus.
    always_ff @(posedge clk) begin
        if (rst) begin
            s1    <= '0;
            s2    <= '0;
            lvl   <= '0;
            lvl_q <= '0;
            for (int i = 0; i < 3; i++) dcnt[i] <= '0;
        end else begin
            s1    <= raw;
            s2    <= s1;
            lvl_q <= lvl;
            for (int i = 0; i < 3; i++) begin
                if (s2[i] == lvl[i]) dcnt[i] <= '0;
                else if (dcnt[i] == D_LAST) begin
                    dcnt[i] <= '0;
                    lvl[i]  <= ~lvl[i];
                end else dcnt[i] <= dcnt[i] + 1'b1;
            end
        end
    end

    // Repeat FSMs; index 0 = add, 1 = minus. A simultaneous press locks both out.
    always_comb begin
        for (int j = 0; j < 2; j++) begin
            st_n[j]   = st[j];
            rcnt_n[j] = rcnt[j];
            pls[j]    = 1'b0;
            if (both) begin
                st_n[j]   = LOCK;
                rcnt_n[j] = '0;
            end else if (!lvl[j+1]) begin
                st_n[j]   = IDLE;
                rcnt_n[j] = '0;
            end else if (st[j] == IDLE && !lvl_q[j+1]) begin
                pls[j]    = 1'b1;
                st_n[j]   = DELAY;
                rcnt_n[j] = RW'(1);
            end else if (st[j] == DELAY || st[j] == REPEAT) begin
                if (rcnt[j] == (st[j] == DELAY ? RD_L : RP_L)) begin
                    pls[j]    = 1'b1;
                    st_n[j]   = REPEAT;
                    rcnt_n[j] = RW'(1);
                end else rcnt_n[j] = rcnt[j] + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int j = 0; j < 2; j++) begin
                st[j]   <= IDLE;
                rcnt[j] <= '0;
            end
            signal <= 1'b0;
            add    <= 1'b0;
            minus  <= 1'b0;
        end else begin
            for (int j = 0; j < 2; j++) begin
                st[j]   <= st_n[j];
                rcnt[j] <= rcnt_n[j];
            end
            signal <= sig_n;
            add    <= pls[0] & ~sig_n;
            minus  <= pls[1] & ~sig_n;
        end
    end
endmodule

// File: tb/tb_fan_button_conditioner.sv
// tb_fan_button_conditioner: directed scenarios plus randomized button activity,
// checked against a timeline model derived from the debounce and repeat rules.
module tb_fan_button_conditioner;
    localparam int D = 4, RD = 8, RP = 4, MAXC = 2048;

    logic clk = 1'b0, rst = 1'b1;
    logic power_btn_raw = 1'b0, add_btn_raw = 1'b0, minus_btn_raw = 1'b0;
    logic signal, add, minus;

    logic [2:0] raw_h [MAXC];
    logic       rst_h [MAXC];
    logic [2:0] obs_h [MAXC];
    logic [2:0] exp_h [MAXC];
    bit         lvl_m [3][MAXC];
    bit         pl_m  [3][MAXC];
    int cyc = 0, checks = 0, passed = 0;

    always #5 clk = ~clk;

    fan_button_conditioner #(.DEBOUNCE_CYCLES(D), .REPEAT_DELAY(RD), .REPEAT_PERIOD(RP)) dut (
        .clk(clk), .rst(rst), .power_btn_raw(power_btn_raw), .add_btn_raw(add_btn_raw),
        .minus_btn_raw(minus_btn_raw), .signal(signal), .add(add), .minus(minus)
    );

    // Edge number cyc samples the inputs set here; outputs after that edge go to obs_h[cyc].
    task automatic step(input logic p, input logic a, input logic m, input logic r);
        power_btn_raw = p;
        add_btn_raw   = a;
        minus_btn_raw = m;
        rst           = r;
        raw_h[cyc] = {m, a, p};
        rst_h[cyc] = r;
        @(posedge clk);
        @(negedge clk);
        obs_h[cyc] = {minus, add, signal};
        cyc++;
    endtask

    // Synchronizer output after edge i: the raw sample of the previous edge, zeroed around reset.
    function automatic bit sync_val(int ch, int i);
        if (i < 1 || rst_h[i] || rst_h[i-1]) return 1'b0;
        return raw_h[i-1][ch];
    endfunction

    function automatic void run_model();
        int r_start [3];
        bit lk [3];
        for (int ch = 0; ch < 3; ch++) begin
            int last = 0;
            for (int c = 0; c < cyc; c++) begin
                bit prev, flip;
                prev = c > 0 ? lvl_m[ch][c-1] : 1'b0;
                if (rst_h[c]) begin
                    lvl_m[ch][c] = 1'b0;
                    last = c;
                end else begin
                    // Level flips once D consecutive post-flip samples all disagree with it.
                    flip = (c - last >= D);
                    if (flip)
                        for (int k = 1; k <= D; k++)
                            if (sync_val(ch, c - k) == prev) flip = 1'b0;
                    lvl_m[ch][c] = flip ? ~prev : prev;
                    if (flip) last = c;
                end
            end
        end
        for (int j = 0; j < 3; j++) begin
            r_start[j] = 0;
            lk[j] = 1'b0;
        end
        for (int t = 0; t < cyc; t++) begin
            for (int j = 1; j < 3; j++) begin
                bit cur, pv;
                int age;
                cur = lvl_m[j][t];
                pv  = t > 0 ? lvl_m[j][t-1] : 1'b0;
                if (cur && !pv) begin
                    r_start[j] = t;
                    lk[j] = 1'b0;
                end
                if (lvl_m[1][t] && lvl_m[2][t]) lk[j] = 1'b1;
                age = t - r_start[j];
                pl_m[j][t] = cur && !lk[j] && (age == 0 || (age >= RD && (age - RD) % RP == 0));
            end
        end
        for (int c = 0; c < cyc; c++) begin
            bit s;
            s = c >= 2 && !rst_h[c] && lvl_m[0][c-1] && !lvl_m[0][c-2];
            exp_h[c][0] = s;
            exp_h[c][1] = c >= 1 && !rst_h[c] && pl_m[1][c-1] && !s;
            exp_h[c][2] = c >= 1 && !rst_h[c] && pl_m[2][c-1] && !s;
        end
    endfunction

    task automatic test_reset();
        int e;
        e = cyc;
        repeat (3) step(0, 0, 0, 1);
        repeat (2) step(1, 1, 1, 1);
        for (int c = e; c < cyc; c++) begin
            checks++;
            if (obs_h[c] !== 3'b000) $display("FAIL reset_outputs cyc=%0d got=%b exp=000", c, obs_h[c]);
            else passed++;
        end
        repeat (8) step(0, 0, 0, 0);
    endtask

    task automatic test_power();
        int e, n;
        e = cyc;
        repeat (20) step(1, 0, 0, 0);
        repeat (15) step(0, 0, 0, 0);
        n = 0;
        for (int c = e; c < cyc; c++) n += int'(obs_h[c][0]);
        checks++;
        if (obs_h[e+6][0] !== 1'b1) $display("FAIL power_latency got=%b exp=1", obs_h[e+6][0]);
        else passed++;
        checks++;
        if (n != 1) $display("FAIL power_pulse_count got=%0d exp=1", n);
        else passed++;
    endtask

    task automatic test_glitch();
        int e, e2, n1, n2;
        e = cyc;
        repeat (3) step(0, 1, 0, 0);
        repeat (10) step(0, 0, 0, 0);
        e2 = cyc;
        repeat (4) step(0, 1, 0, 0);
        repeat (12) step(0, 0, 0, 0);
        n1 = 0;
        n2 = 0;
        for (int c = e; c < e2; c++) n1 += int'(obs_h[c][1]);
        for (int c = e2; c < cyc; c++) n2 += int'(obs_h[c][1]);
        checks++;
        if (n1 != 0) $display("FAIL glitch_rejected got=%0d exp=0", n1);
        else passed++;
        checks++;
        if (n2 != 1) $display("FAIL min_press_count got=%0d exp=1", n2);
        else passed++;
        checks++;
        if (obs_h[e2+6][1] !== 1'b1) $display("FAIL min_press_latency got=%b exp=1", obs_h[e2+6][1]);
        else passed++;
    endtask

    task automatic test_add_hold();
        int e;
        bit x;
        e = cyc;
        repeat (30) step(0, 1, 0, 0);
        repeat (15) step(0, 0, 0, 0);
        for (int o = 0; o < 45; o++) begin
            x = (o == 6) || (o >= 14 && o <= 34 && (o - 14) % 4 == 0);
            checks++;
            if (obs_h[e+o][1] !== x) $display("FAIL add_repeat off=%0d got=%b exp=%b", o, obs_h[e+o][1], x);
            else passed++;
        end
    endtask

    task automatic test_conflict();
        int e_m, e_a, e2, n;
        e_m = cyc;
        repeat (20) step(0, 0, 1, 0);
        e_a = cyc;
        repeat (15) step(0, 1, 1, 0);
        repeat (10) step(0, 0, 1, 0);
        repeat (10) step(0, 0, 0, 0);
        e2 = cyc;
        repeat (10) step(0, 1, 0, 0);
        repeat (10) step(0, 0, 0, 0);
        checks++;
        if (obs_h[e_m+6][2] !== 1'b1) $display("FAIL minus_first got=%b exp=1", obs_h[e_m+6][2]);
        else passed++;
        n = 0;
        for (int c = e_a + 6; c < e2; c++) n += int'(obs_h[c][1]) + int'(obs_h[c][2]);
        checks++;
        if (n != 0) $display("FAIL conflict_lock got=%0d exp=0", n);
        else passed++;
        checks++;
        if (obs_h[e2+6][1] !== 1'b1) $display("FAIL add_after_lock got=%b exp=1", obs_h[e2+6][1]);
        else passed++;
    endtask

    task automatic test_power_add();
        int e;
        e = cyc;
        repeat (16) step(1, 1, 0, 0);
        repeat (15) step(0, 0, 0, 0);
        checks++;
        if (obs_h[e+6][1:0] !== 2'b01) $display("FAIL power_mask got=%b exp=01", obs_h[e+6][1:0]);
        else passed++;
        checks++;
        if (obs_h[e+14][1] !== 1'b1) $display("FAIL masked_repeat got=%b exp=1", obs_h[e+14][1]);
        else passed++;
        checks++;
        if (obs_h[e+18][1] !== 1'b1) $display("FAIL masked_repeat2 got=%b exp=1", obs_h[e+18][1]);
        else passed++;
    endtask

    task automatic test_reset_mid();
        int e, e1, r0;
        e = cyc;
        repeat (23) step(0, 1, 0, 0);
        r0 = cyc;
        repeat (2) step(0, 1, 0, 1);
        e1 = cyc;
        repeat (25) step(0, 1, 0, 0);
        repeat (15) step(0, 0, 0, 0);
        checks++;
        if (obs_h[e+22][1] !== 1'b1) $display("FAIL pre_reset_repeat got=%b exp=1", obs_h[e+22][1]);
        else passed++;
        for (int c = r0; c < e1; c++) begin
            checks++;
            if (obs_h[c] !== 3'b000) $display("FAIL mid_reset_out cyc=%0d got=%b exp=000", c, obs_h[c]);
            else passed++;
        end
        checks++;
        if (obs_h[e1+5][1] !== 1'b0) $display("FAIL post_reset_early got=%b exp=0", obs_h[e1+5][1]);
        else passed++;
        checks++;
        if (obs_h[e1+6][1] !== 1'b1) $display("FAIL post_reset_first got=%b exp=1", obs_h[e1+6][1]);
        else passed++;
        checks++;
        if (obs_h[e1+10][1] !== 1'b0) $display("FAIL post_reset_gap got=%b exp=0", obs_h[e1+10][1]);
        else passed++;
        checks++;
        if (obs_h[e1+14][1] !== 1'b1) $display("FAIL post_reset_rep1 got=%b exp=1", obs_h[e1+14][1]);
        else passed++;
        checks++;
        if (obs_h[e1+18][1] !== 1'b1) $display("FAIL post_reset_rep2 got=%b exp=1", obs_h[e1+18][1]);
        else passed++;
    endtask

    task automatic test_random();
        repeat (45) begin
            logic p, a, m;
            int n;
            p = $urandom_range(0, 3) == 0;
            a = $urandom_range(0, 1) == 1;
            m = $urandom_range(0, 2) == 0;
            n = $urandom_range(1, 14);
            if ($urandom_range(0, 15) == 0) repeat ($urandom_range(1, 3)) step(p, a, m, 1);
            repeat (n) step(p, a, m, 0);
        end
        repeat (20) step(0, 0, 0, 0);
        run_model();
        for (int c = 0; c < cyc; c++) begin
            checks++;
            if (obs_h[c] !== exp_h[c]) $display("FAIL model cyc=%0d got=%b exp=%b", c, obs_h[c], exp_h[c]);
            else passed++;
        end
    endtask

    initial begin
        test_reset();
        test_power();
        test_glitch();
        test_add_hold();
        test_conflict();
        test_power_add();
        test_reset_mid();
        test_random();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end
endmodule
